// File: rtl/pc_unit_pkg.sv
// Shared types and default sizing for the program-counter unit.
package pc_unit_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } pc_state_t;

  localparam int          DEF_WIDTH    = 32;
  localparam int          DEF_NUM_SRC  = 6;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_src_mux.sv
// Combinational NUM_SRC-way selector, zero latency, no flow control.
// An out-of-range select returns the last entry.
module pc_src_mux #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 6,
  parameter int SEL_W   = 3
) (
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         sel_data
);

  always_comb begin
    sel_data = src_data[(NUM_SRC-1)*WIDTH +: WIDTH];
    for (int i = 0; i < NUM_SRC - 1; i++) begin
      if (sel == SEL_W'(i)) sel_data = src_data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pc_unit_buffered.sv
// Registered PC with one-deep redirect buffer; loads appear one cycle after acceptance,
// hold stalls the PC and parks the latest redirect. Optional commit history: PC_HISTORY_EN.
module pc_unit_buffered
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               NUM_SRC    = DEF_NUM_SRC,
  parameter int               SEL_W      = 3,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEF_RESET_PC),
  parameter int               ALIGN_BITS = 2,
  parameter int               HIST_DEPTH = 8,
  localparam int              HIST_W     = $clog2(HIST_DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     branch_taken,
  input  logic                     hold,
  output logic [WIDTH-1:0]         pc,
  output logic                     pc_updated,
  output logic                     redirect_pending,
  output logic                     sel_error,
  output logic                     misaligned,
  input  logic [HIST_W-1:0]        hist_idx,
  output logic [WIDTH-1:0]         hist_pc
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  pc_state_t        state;
  logic [WIDTH-1:0] pend_reg;
  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] load_val;
  logic             req;
  logic             sel_oor;
  logic             load;

  assign req     = pc_write | (pc_write_cond & branch_taken);
  assign sel_oor = int'(src_sel) >= NUM_SRC;

  pc_src_mux #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_src_mux (
    .src_data (src_data),
    .sel      (src_sel),
    .sel_data (sel_val)
  );

  // A fresh request always beats the buffered redirect.
  pc_src_mux #(
    .WIDTH   (WIDTH),
    .NUM_SRC (2),
    .SEL_W   (1)
  ) u_load_mux (
    .src_data ({sel_val, pend_reg}),
    .sel      (req),
    .sel_data (load_val)
  );

  always_comb begin
    load = 1'b0;
    case (state)
      IDLE:    load = req & ~hold;
      PENDING: load = ~hold;
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      pend_reg         <= '0;
      pc_updated       <= 1'b0;
      redirect_pending <= 1'b0;
      sel_error        <= 1'b0;
      misaligned       <= 1'b0;
    end else begin
      pc_updated <= load;
      if (load) begin
        pc <= load_val;
        if ((load_val & ALIGN_MASK) != '0) misaligned <= 1'b1;
      end
      if (req && sel_oor) sel_error <= 1'b1;

      case (state)
        IDLE: begin
          if (hold && req) begin
            pend_reg         <= sel_val;
            state            <= PENDING;
            redirect_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (hold) begin
            if (req) pend_reg <= sel_val;
          end else begin
            state            <= IDLE;
            redirect_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PC_HISTORY_EN
  logic [WIDTH-1:0]  hist_mem [HIST_DEPTH];
  logic [HIST_W-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
    end else if (load) begin
      hist_mem[wr_ptr] <= load_val;
      wr_ptr           <= wr_ptr + HIST_W'(1);
    end
  end

  // Index 0 is the most recent commit, one slot behind the write pointer.
  assign hist_pc = hist_mem[wr_ptr - HIST_W'(1) - hist_idx];
`else
  logic hist_unused;
  assign hist_unused = ^hist_idx;
  assign hist_pc     = '0;
`endif

endmodule

// File: tb/tb_pc_unit_buffered.sv
// Directed plus randomized bench for pc_unit_buffered against a queue-based reference model.
module tb_pc_unit_buffered;

  logic         clk = 1'b0;
  logic         reset;
  logic [191:0] src_data;
  logic [2:0]   src_sel;
  logic         pc_write, pc_write_cond, branch_taken, hold;
  logic [31:0]  pc;
  logic         pc_updated, redirect_pending, sel_error, misaligned;
  logic [2:0]   hist_idx;
  logic [31:0]  hist_pc;

  logic [31:0]  ent [6];

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_upd, m_pend, m_selerr, m_mis;
  logic [31:0] m_pval;
  logic [31:0] m_hist [$];

  pc_unit_buffered dut (
    .clk              (clk),
    .reset            (reset),
    .src_data         (src_data),
    .src_sel          (src_sel),
    .pc_write         (pc_write),
    .pc_write_cond    (pc_write_cond),
    .branch_taken     (branch_taken),
    .hold             (hold),
    .pc               (pc),
    .pc_updated       (pc_updated),
    .redirect_pending (redirect_pending),
    .sel_error        (sel_error),
    .misaligned       (misaligned),
    .hist_idx         (hist_idx),
    .hist_pc          (hist_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: update the model from the current inputs, clock the DUT, compare.
  task automatic cyc();
    logic        req, ld;
    logic [31:0] sv, v;
    int          si;
    for (int i = 0; i < 6; i++) src_data[i*32 +: 32] = ent[i];
    req = pc_write | (pc_write_cond & branch_taken);
    si  = (src_sel < 3'd6) ? int'(src_sel) : 5;
    sv  = ent[si];
    v   = '0;
    ld  = 1'b0;
    if (reset) begin
      m_pc = 32'h0; m_upd = 0; m_pend = 0; m_pval = '0; m_selerr = 0; m_mis = 0;
      m_hist = {};
      for (int i = 0; i < 8; i++) m_hist.push_back(32'h0);
    end else begin
      if (req && src_sel >= 3'd6) m_selerr = 1;
      if (!hold) begin
        if (req) begin ld = 1; v = sv; end
        else if (m_pend) begin ld = 1; v = m_pval; end
        m_pend = 0;
      end else if (req) begin
        m_pend = 1;
        m_pval = sv;
      end
      m_upd = ld;
      if (ld) begin
        m_pc = v;
        if (v[1:0] != 2'b00) m_mis = 1;
        m_hist.push_front(v);
        void'(m_hist.pop_back());
      end
    end
    @(posedge clk);
    #1;
    hist_idx = 3'($urandom_range(0, 7));
    #1;
    check("pc", pc, m_pc);
    check("pc_updated", {31'b0, pc_updated}, {31'b0, m_upd});
    check("redirect_pending", {31'b0, redirect_pending}, {31'b0, m_pend});
    check("sel_error", {31'b0, sel_error}, {31'b0, m_selerr});
    check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
`ifdef PC_HISTORY_EN
    check("hist_pc", hist_pc, m_hist[hist_idx]);
`else
    check("hist_pc", hist_pc, 32'h0);
`endif
  endtask

  initial begin
    reset = 1; src_sel = 0; pc_write = 0; pc_write_cond = 0; branch_taken = 0; hold = 0;
    hist_idx = 0;
    for (int i = 0; i < 6; i++) ent[i] = 32'h0;
    src_data = '0;
    cyc(); cyc();
    check("reset_pc", pc, 32'h0);
    reset = 0;

    // Unconditional load
    ent[2] = 32'h40; src_sel = 2; pc_write = 1;
    cyc();
    check("load_pc", pc, 32'h40);
    check("load_pulse", {31'b0, pc_updated}, 32'h1);
    pc_write = 0;
    cyc();
    check("pulse_drop", {31'b0, pc_updated}, 32'h0);

    // Conditional write, not taken then taken
    ent[1] = 32'h100; src_sel = 1; pc_write_cond = 1; branch_taken = 0;
    cyc();
    check("cond_not_taken", pc, 32'h40);
    branch_taken = 1;
    cyc();
    check("cond_taken", pc, 32'h100);
    pc_write_cond = 0; branch_taken = 0;

    // Held redirect, latest wins
    hold = 1; pc_write = 1; ent[3] = 32'h200; src_sel = 3;
    cyc();
    check("held_pc", pc, 32'h100);
    check("held_pending", {31'b0, redirect_pending}, 32'h1);
    ent[4] = 32'h300; src_sel = 4;
    cyc();
    hold = 0; pc_write = 0;
    cyc();
    check("release_pc", pc, 32'h300);
    check("release_pending", {31'b0, redirect_pending}, 32'h0);

    // Out-of-range select and misaligned target
    ent[5] = 32'h500; src_sel = 7; pc_write = 1;
    cyc();
    check("oor_pc", pc, 32'h500);
    check("oor_err", {31'b0, sel_error}, 32'h1);
    ent[5] = 32'h502; src_sel = 5;
    cyc();
    check("mis_pc", pc, 32'h502);
    check("mis_flag", {31'b0, misaligned}, 32'h1);
    pc_write = 0;
    cyc();
    check("err_sticky", {31'b0, sel_error}, 32'h1);

    // Reset while a redirect is buffered
    hold = 1; pc_write = 1; ent[0] = 32'h600; src_sel = 0;
    cyc();
    hold = 0; pc_write = 0; reset = 1;
    cyc();
    check("rst_pend_pc", pc, 32'h0);
    check("rst_pend_flag", {31'b0, redirect_pending}, 32'h0);
    reset = 0;
    cyc();
    check("rst_no_replay", pc, 32'h0);

`ifdef PC_HISTORY_EN
    pc_write = 1; src_sel = 0;
    for (int k = 1; k <= 10; k++) begin
      ent[0] = 32'(4 * k);
      cyc();
    end
    pc_write = 0;
    hist_idx = 3'd0; #1;
    check("hist_newest", hist_pc, 32'h28);
    hist_idx = 3'd7; #1;
    check("hist_oldest", hist_pc, 32'hC);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 6; i++) begin
        ent[i] = $urandom;
        if ($urandom_range(0, 3) != 0) ent[i][1:0] = 2'b00;
      end
      src_sel       = 3'($urandom_range(0, 7));
      pc_write      = ($urandom_range(0, 2) == 0);
      pc_write_cond = $urandom_range(0, 1) == 1;
      branch_taken  = $urandom_range(0, 1) == 1;
      hold          = ($urandom_range(0, 2) == 0);
      reset         = ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
